// File: rtl/encoder_pwm_bank.sv
// encoder_pwm_bank: NUM_CH rotary-encoder channels. Each channel keeps a level
// register driven by encoder detents or a host load, and drives a PWM output
// from that level.
//
// Ports:
//   clk, reset         single clock; synchronous active-high reset
//   enc_a, enc_b       [NUM_CH] asynchronous encoder phases
//   load_en/ch/val     one-cycle host write of a level (load_ch >= NUM_CH ignored)
//   level_o            [NUM_CH*WIDTH] levels, channel i at [i*WIDTH +: WIDTH]
//   pwm_out            [NUM_CH] registered PWM outputs
//   period_tick        high while the shared PWM counter is at its last count

// Per-channel datapath: sync, debounce, X1 decode, level register, PWM compare.
module encoder_pwm_ch #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] pwm_cnt,
    input  logic             period_end,
    output logic [WIDTH-1:0] level,
    output logic             pwm_out
);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [1:0]       a_sync, b_sync;
    logic             a_smp, b_smp;   // previous strobe sample; the current one is the sync output
    logic             a_db, b_db, a_db_q;
    logic             up_ev, dn_ev;
    logic [WIDTH-1:0] shadow, level_nxt;
    logic [WIDTH:0]   inc, dec;

    // One extra bit exposes overflow/borrow for the clamp decision.
    always_comb begin
        inc       = {1'b0, level} + STEP_X;
        dec       = {1'b0, level} - STEP_X;
        level_nxt = level;
        if (load)
            level_nxt = load_val;       // a same-cycle detent is dropped
        else if (up_ev)
            level_nxt = (SATURATE != 0 && inc[WIDTH]) ? '1 : inc[WIDTH-1:0];
        else if (dn_ev)
            level_nxt = (SATURATE != 0 && dec[WIDTH]) ? '0 : dec[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync  <= '0;
            b_sync  <= '0;
            a_smp   <= 1'b0;
            b_smp   <= 1'b0;
            a_db    <= 1'b0;
            b_db    <= 1'b0;
            a_db_q  <= 1'b0;
            up_ev   <= 1'b0;
            dn_ev   <= 1'b0;
            level   <= '0;
            shadow  <= '0;
            pwm_out <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], enc_a};
            b_sync <= {b_sync[0], enc_b};
            // Two consecutive strobe samples must agree before the debounced
            // value moves, so anything shorter than one strobe interval is lost.
            if (strobe) begin
                a_smp <= a_sync[1];
                b_smp <= b_sync[1];
                if (a_smp == a_sync[1]) a_db <= a_sync[1];
                if (b_smp == b_sync[1]) b_db <= b_sync[1];
            end
            a_db_q  <= a_db;
            up_ev   <= a_db & ~a_db_q & ~b_db;
            dn_ev   <= a_db & ~a_db_q &  b_db;
            level   <= level_nxt;
            // Duty is only sampled at period end so a running pulse is never cut.
            if (period_end) shadow <= level;
            pwm_out <= shadow > pwm_cnt;
        end
    end
endmodule

module encoder_pwm_bank #(
    parameter int NUM_CH       = 3,
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_DIV = 1024,
    parameter int STEP         = 1,
    parameter int SATURATE     = 1,
    parameter int CH_W         = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    load_en,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [WIDTH-1:0]        load_val,
    output logic [NUM_CH*WIDTH-1:0] level_o,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick
);
    localparam int PRE_W = $clog2(DEBOUNCE_DIV);

    logic [PRE_W-1:0]              pre;
    logic                          strobe;
    logic [WIDTH-1:0]              pwm_cnt;
    logic                          period_end;
    logic [NUM_CH-1:0][WIDTH-1:0]  level;

    assign strobe      = (pre == PRE_W'(DEBOUNCE_DIV - 1));
    assign period_end  = &pwm_cnt;
    assign period_tick = period_end;
    assign level_o     = level;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else begin
            pre     <= strobe ? '0 : pre + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
        logic ld;
        // Out-of-range load_ch matches no channel.
        assign ld = load_en && (load_ch == CH_W'(gi));

        encoder_pwm_ch #(
            .WIDTH   (WIDTH),
            .STEP    (STEP),
            .SATURATE(SATURATE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .strobe    (strobe),
            .enc_a     (enc_a[gi]),
            .enc_b     (enc_b[gi]),
            .load      (ld),
            .load_val  (load_val),
            .pwm_cnt   (pwm_cnt),
            .period_end(period_end),
            .level     (level[gi]),
            .pwm_out   (pwm_out[gi])
        );
    end
endmodule

// File: tb/tb_encoder_pwm_bank.sv
// Bench for encoder_pwm_bank: a saturating and a wrapping instance share all
// stimulus. Table vectors push expected level vectors to a scoreboard queue
// and compare once the operation has settled; hand sequences cover PWM
// shadowing, glitch rejection, load priority and mid-period reset.
module tb_encoder_pwm_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  enc_a = '0, enc_b = '0;
    logic        load_en = 1'b0;
    logic [1:0]  load_ch = '0;
    logic [7:0]  load_val = '0;
    logic [23:0] lvl_s, lvl_w;
    logic [2:0]  pwm_s, pwm_w;
    logic        tick_s, tick_w;

    always #5 clk = ~clk;

    encoder_pwm_bank #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_DIV(4), .STEP(1), .SATURATE(1)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load_en(load_en),
        .load_ch(load_ch), .load_val(load_val), .level_o(lvl_s), .pwm_out(pwm_s),
        .period_tick(tick_s));

    encoder_pwm_bank #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_DIV(4), .STEP(1), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load_en(load_en),
        .load_ch(load_ch), .load_val(load_val), .level_o(lvl_w), .pwm_out(pwm_w),
        .period_tick(tick_w));

    typedef enum {OP_UP, OP_DN, OP_LD} op_t;
    typedef struct {
        op_t         op;
        int          ch;
        int          val;
        logic [23:0] exp_s;
        logic [23:0] exp_w;
    } vec_t;
    typedef struct {
        logic [23:0] s;
        logic [23:0] w;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0, bad = 0;
    int   hs[3], hw[3];
    bit   seen;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [23:0] pk(int c2, int c1, int c0);
        return {c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic detent(int ch, bit down);
        if (down) begin enc_b[ch] = 1'b1; step(16); end
        enc_a[ch] = 1'b1; step(16);
        enc_a[ch] = 1'b0; step(16);
        if (down) begin enc_b[ch] = 1'b0; step(16); end
    endtask

    task automatic do_load(int ch, int val);
        load_ch  = ch[1:0];
        load_val = val[7:0];
        load_en  = 1'b1;
        step(1);
        load_en  = 1'b0;
        step(1);
    endtask

    // Returns at the negedge where pwm_cnt == 255.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tick_s) begin ok = 1'b1; break; end
        end
    endtask

    // Count high cycles of every output over one period aligned to pwm_cnt=0;
    // optionally issue a load while pwm_cnt == ld_at.
    task automatic measure(int ld_at, int ld_ch, int ld_val);
        bit ok;
        wait_tick(ok);
        chk("tick_found", {31'b0, ok}, 32'd1);
        hs = '{0, 0, 0};
        hw = '{0, 0, 0};
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (k == ld_at) begin
                load_ch  = ld_ch[1:0];
                load_val = ld_val[7:0];
                load_en  = 1'b1;
            end else begin
                load_en  = 1'b0;
            end
            for (int c = 0; c < 3; c++) begin
                hs[c] += int'(pwm_s[c]);
                hw[c] += int'(pwm_w[c]);
            end
        end
        load_en = 1'b0;
    endtask

    initial begin
        int first_tick, second_tick, nz, cnt;
        bit ok;
        exp_t e;

        // ---- reset with random encoder activity ----
        enc_a = 3'($urandom); enc_b = 3'($urandom);
        @(negedge clk);
        chk("rst_level_s", {8'b0, lvl_s}, 32'd0);
        chk("rst_pwm_s", {29'b0, pwm_s}, 32'd0);
        chk("rst_tick", {31'b0, tick_s}, 32'd0);
        repeat (2) begin
            enc_a = 3'($urandom); enc_b = 3'($urandom);
            @(negedge clk);
        end
        enc_a = '0; enc_b = '0; reset = 1'b0;
        first_tick = -1; second_tick = -1; nz = 0;
        for (int j = 1; j <= 512; j++) begin
            @(negedge clk);
            if (lvl_s != 0 || lvl_w != 0 || pwm_s != 0 || pwm_w != 0) nz++;
            if (tick_s) begin
                if (first_tick < 0) first_tick = j;
                else if (second_tick < 0) second_tick = j;
            end
        end
        chk("rst_quiet_outputs", nz, 0);
        chk("rst_first_tick", first_tick, 255);
        chk("rst_second_tick", second_tick, 511);
        step(1);

        // ---- table-driven detent / load vectors ----
        for (int i = 1; i <= 5; i++)
            vecs.push_back('{OP_UP, 0, 0, pk(0, 0, i), pk(0, 0, i)});
        vecs.push_back('{OP_LD, 1, 254, pk(0, 254, 5), pk(0, 254, 5)});
        vecs.push_back('{OP_UP, 1, 0, pk(0, 255, 5), pk(0, 255, 5)});
        vecs.push_back('{OP_UP, 1, 0, pk(0, 255, 5), pk(0, 0, 5)});
        vecs.push_back('{OP_UP, 1, 0, pk(0, 255, 5), pk(0, 1, 5)});
        vecs.push_back('{OP_LD, 2, 0, pk(0, 255, 5), pk(0, 1, 5)});
        vecs.push_back('{OP_DN, 2, 0, pk(0, 255, 5), pk(255, 1, 5)});
        vecs.push_back('{OP_LD, 3, 77, pk(0, 255, 5), pk(255, 1, 5)});

        foreach (vecs[i]) begin
            sb.push_back('{vecs[i].exp_s, vecs[i].exp_w});
            case (vecs[i].op)
                OP_UP:   detent(vecs[i].ch, 1'b0);
                OP_DN:   detent(vecs[i].ch, 1'b1);
                default: do_load(vecs[i].ch, vecs[i].val);
            endcase
            e = sb.pop_front();
            chk($sformatf("vec%0d_sat", i), {8'b0, lvl_s}, {8'b0, e.s});
            chk($sformatf("vec%0d_wrap", i), {8'b0, lvl_w}, {8'b0, e.w});
        end

        // ---- steady-state PWM duty ----
        measure(-1, 0, 0);
        chk("pwm_s_ch0", hs[0], 5);
        chk("pwm_s_ch1", hs[1], 255);
        chk("pwm_s_ch2", hs[2], 0);
        chk("pwm_w_ch0", hw[0], 5);
        chk("pwm_w_ch1", hw[1], 1);
        chk("pwm_w_ch2", hw[2], 255);
        step(1);

        // ---- glitch rejection ----
        enc_a[0] = 1'b1; step(1); enc_a[0] = 1'b0; step(20);
        enc_a[0] = 1'b1; step(3); enc_a[0] = 1'b0; step(20);
        chk("glitch_s_ch0", {24'b0, lvl_s[7:0]}, 32'd5);
        chk("glitch_w_ch0", {24'b0, lvl_w[7:0]}, 32'd5);
        enc_a[0] = 1'b1; step(12); enc_a[0] = 1'b0; step(20);
        chk("stable_s_ch0", {24'b0, lvl_s[7:0]}, 32'd6);
        chk("stable_w_ch0", {24'b0, lvl_w[7:0]}, 32'd6);

        // ---- shadow duty: load mid-period only affects the next period ----
        do_load(2, 10);
        measure(-1, 0, 0);
        chk("shadow_pre", hs[2], 10);
        measure(50, 2, 200);
        chk("shadow_cur_s", hs[2], 10);
        chk("shadow_cur_w", hw[2], 10);
        measure(-1, 0, 0);
        chk("shadow_next_s", hs[2], 200);
        chk("shadow_next_w", hw[2], 200);
        step(1);

        // ---- load wins over a coincident detent on the same channel ----
        seen = 1'b0;
        fork
            detent(1, 1'b0);
            begin
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (dut.gen_ch[1].u_ch.up_ev) begin
                        load_ch = 2'd1; load_val = 8'd100; load_en = 1'b1;
                        seen = 1'b1;
                        @(negedge clk);
                        load_en = 1'b0;
                        break;
                    end
                end
            end
        join
        step(4);
        chk("prio_event_seen", {31'b0, seen}, 32'd1);
        chk("prio_s", {8'b0, lvl_s}, {8'b0, pk(200, 100, 6)});
        chk("prio_w", {8'b0, lvl_w}, {8'b0, pk(200, 100, 6)});

        // ---- reset mid-period ----
        do_load(0, 100);
        measure(-1, 0, 0);
        chk("pre_rst_duty", hs[0], 100);
        wait_tick(ok);
        chk("tick_found_rst", {31'b0, ok}, 32'd1);
        repeat (21) @(negedge clk);             // pwm_cnt == 20
        chk("pre_rst_pwm0", {31'b0, pwm_s[0]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_level_s", {8'b0, lvl_s}, 32'd0);
        chk("mid_rst_level_w", {8'b0, lvl_w}, 32'd0);
        chk("mid_rst_pwm", {26'b0, pwm_s, pwm_w}, 32'd0);
        chk("mid_rst_tick", {31'b0, tick_s}, 32'd0);
        cnt = -1;
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk);
            if (tick_s) begin cnt = j; break; end
        end
        chk("mid_rst_cnt_restart", cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/encoder_pwm_bank.md
Name: encoder_pwm_bank

Overview:
Parametrised N-channel successor to the fixed 3-channel encoder/PWM mixer. Per channel: synchronise and debounce a rotary encoder, decode detents into a saturating or wrapping level register, and drive a glitch-free PWM output. It adds a host load port (driven from LA/wishbone glue in the wrapper) and level readback. It is instantiated inside the project wrapper, with encoder pins on io_in, PWM outputs on io_out and reset from la_data_in[0].

Parameters:
NUM_CH, 3, number of channels (>=2)
WIDTH, 8, level/PWM resolution in bits; PWM period = 2^WIDTH clocks
DEBOUNCE_DIV, 1024, clocks between debounce samples (>=2)
STEP, 1, level increment/decrement per detent (1..2^WIDTH-1)
SATURATE, 1, 1 = clamp at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH
CH_W, $clog2(NUM_CH), width of load_ch

Ports:
clk  input  1  system clock (wb_clk_i); single clock domain
reset  input  1  synchronous, active-high reset
enc_a  input  NUM_CH  encoder A phase per channel, asynchronous
enc_b  input  NUM_CH  encoder B phase per channel, asynchronous
load_en  input  1  one-cycle strobe: write load_val into channel load_ch
load_ch  input  CH_W  target channel for load
load_val  input  WIDTH  value to load
level_o  output  NUM_CH*WIDTH  current levels; channel i at [i*WIDTH +: WIDTH]
pwm_out  output  NUM_CH  PWM output per channel, registered
period_tick  output  1  high for the cycle in which pwm_cnt == 2^WIDTH-1

Behaviour:
- Reset (sampled on posedge clk while reset=1) clears all state: sync flops, debounce samples, debounced A/B, prescaler, pwm_cnt, levels, shadow duties. pwm_out=0, level_o=0 and period_tick=0 from the first clock edge with reset high. Asserting reset mid-period aborts the period; pwm_cnt restarts at 0.
- Sync: 2-flop synchroniser on every enc_a/enc_b bit.
- Prescaler: counts 0..DEBOUNCE_DIV-1 and wraps. strobe=1 in the cycle where the count is DEBOUNCE_DIV-1.
- Debounce: on strobe, each line shifts its synchronised value into a 2-sample register. The debounced value updates only when both samples agree; otherwise it holds. A pulse shorter than DEBOUNCE_DIV clocks never changes the debounced value.
- Decode (X1): detent event when debounced A goes 0->1, registered as one cycle of edge detect. B (debounced) = 0 -> up; B = 1 -> down. At most one event per channel per strobe interval.
- Level update, in the cycle after the event:
  - Up: SATURATE=1 gives min(level+STEP, 2^WIDTH-1); SATURATE=0 gives (level+STEP) mod 2^WIDTH.
  - Down: SATURATE=1 gives max(level-STEP, 0); SATURATE=0 gives (level-STEP) mod 2^WIDTH.
  - Use WIDTH+1-bit arithmetic for the clamp comparison.
- Load: when load_en=1 and load_ch<NUM_CH, level[load_ch] <= load_val on the next edge. Load takes priority over a same-cycle encoder event on that channel; the event is dropped. load_ch>=NUM_CH is ignored. Other channels' events in the same cycle still apply.
- level_o: direct register output, visible the cycle after the update.
- PWM:
  - One shared free-running pwm_cnt, 0..2^WIDTH-1, wrapping.
  - When pwm_cnt==2^WIDTH-1, each channel's shadow duty <= level, so the new duty takes effect from pwm_cnt==0.
  - pwm_out[i] <= (shadow[i] > pwm_cnt): registered, one cycle of latency relative to pwm_cnt.
  - Level 0 gives constant low. Level L gives L high cycles per 2^WIDTH-cycle period, contiguous at period start. Output is never 100% high.
- Level changes mid-period never truncate or extend the current pulse (no glitches).
- Latency, encoder edge to level_o: 2 sync cycles + up to 2 strobe intervals + 2 cycles.

Test Plan:
- All tests use NUM_CH=3, WIDTH=8, DEBOUNCE_DIV=4, STEP=1, SATURATE=1 unless stated.
- Reset: hold reset for 3 cycles with random encoder inputs -> level_o=0, pwm_out=0 for the following 256 cycles, period_tick pulses every 256 cycles.
- Five up detents on ch0 (A rises with B=0, each phase held 16 clocks) -> level ch0=5, ch1/ch2=0. Next full period: pwm_out[0] high for exactly 5 of 256 cycles.
- Saturate/wrap: load ch1=254 then 3 up detents -> 255. Load ch2=0 then 1 down detent -> 0. With SATURATE=0, the same sequences give 1 and 255.
- Glitch rejection: 1- and 3-clock A pulses on ch0 -> level unchanged. A 12-clock stable edge -> +1.
- Shadow/priority: ch2=10, load 200 at pwm_cnt=50 -> current period high 10 cycles, next period 200. A load on ch1 coinciding with a ch1 up event -> level = load_val. load_ch=3 -> no change.
- Reset mid-operation: level ch0=100 and pwm_out[0]=1 at pwm_cnt=20, reset for 1 cycle -> all levels 0, pwm_out 0 at the next edge, pwm_cnt restarts at 0.
